// File: rtl/rgb_ycc_conv_if.sv
// rgb_ycc_conv_if: pixel-in / pixel-out valid-ready bundle for rgb_ycc_conv.
// The master drives input pixels and output backpressure. The slave (the
// converter) drives input readiness and the converted pixel stream.
interface rgb_ycc_conv_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic [7:0] cb;
   logic [7:0] cr;
   logic       block_done;

   modport master (
      output in_valid, r, g, b, out_ready,
      input  in_ready, out_valid, y, cb, cr, block_done
   );

   modport slave (
      input  in_valid, r, g, b, out_ready,
      output in_ready, out_valid, y, cb, cr, block_done
   );
endinterface

// File: rtl/rgb_ycc_conv.sv
// rgb_ycc_conv: three-stage integer RGB -> YCbCr converter.
// S1 forms nine coefficient products, S2 adds the rounding constant to three
// sums, and S3 shifts, offsets and clamps into the output register.
// A single stall (out_valid & ~out_ready) freezes every stage at once.
// block_done marks the last pixel of each BLOCK_PIXELS group.
module rgb_ycc_conv #(
   parameter int BLOCK_PIXELS = 64
) (
   input  logic          clk,
   input  logic          reset,
   rgb_ycc_conv_if.slave bus
);
   localparam int CW = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_PIXELS - 1);

   typedef logic signed [17:0] s18_t;

   localparam s18_t K_Y_R  =  18'sd77,  K_Y_G  =  18'sd150, K_Y_B  =  18'sd29;
   localparam s18_t K_CB_R = -18'sd43,  K_CB_G = -18'sd85,  K_CB_B =  18'sd128;
   localparam s18_t K_CR_R =  18'sd128, K_CR_G = -18'sd107, K_CR_B = -18'sd21;
   localparam s18_t ROUND  =  18'sd128;

   // Coefficient times zero-extended component. Every product fits in 18 signed bits.
   function automatic s18_t mul(input s18_t k, input logic [7:0] c);
      return k * s18_t'({10'd0, c});
   endfunction

   // Floor-shift the rounded sum, add the chroma offset, saturate to 0..255.
   function automatic logic [7:0] scale(input s18_t sum, input s18_t offset);
      s18_t v;
      v = (sum >>> 8) + offset;
      if (v < 18'sd0)   return 8'd0;
      if (v > 18'sd255) return 8'd255;
      return v[7:0];
   endfunction

   logic            v1, v2, v3;
   s18_t            p_y [3];
   s18_t            p_cb[3];
   s18_t            p_cr[3];
   s18_t            s_y, s_cb, s_cr;
   logic [7:0]      y_q, cb_q, cr_q;
   logic [CW-1:0]   cnt;
   logic            stall;
   logic            advance;

   assign stall          = v3 & ~bus.out_ready;
   assign advance        = ~stall;
   assign bus.in_ready   = advance;
   assign bus.out_valid  = v3;
   assign bus.y          = y_q;
   assign bus.cb         = cb_q;
   assign bus.cr         = cr_q;
   assign bus.block_done = v3 & (cnt == LAST_IDX);

   // Stage valid bits advance together unless the output is stalled.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every stage samples its upstream
      // neighbour's pre-edge value, regardless of statement order.
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (advance) begin
         v1 <= bus.in_valid;
         v2 <= v1;
         v3 <= v2;
      end
   end

   // S1 products and S2 rounded sums are loaded only when a valid pixel moves in.
   always_ff @(posedge clk) begin
      // NOTE: the datapath has no reset. The valid bits alone say whether
      // these registers hold a pixel, so clearing them would gain nothing.
      if (advance && bus.in_valid) begin
         p_y[0]  <= mul(K_Y_R,  bus.r);
         p_y[1]  <= mul(K_Y_G,  bus.g);
         p_y[2]  <= mul(K_Y_B,  bus.b);
         p_cb[0] <= mul(K_CB_R, bus.r);
         p_cb[1] <= mul(K_CB_G, bus.g);
         p_cb[2] <= mul(K_CB_B, bus.b);
         p_cr[0] <= mul(K_CR_R, bus.r);
         p_cr[1] <= mul(K_CR_G, bus.g);
         p_cr[2] <= mul(K_CR_B, bus.b);
      end
      if (advance && v1) begin
         s_y  <= p_y[0]  + p_y[1]  + p_y[2]  + ROUND;
         s_cb <= p_cb[0] + p_cb[1] + p_cb[2] + ROUND;
         s_cr <= p_cr[0] + p_cr[1] + p_cr[2] + ROUND;
      end
   end

   // S3 output register: shift, offset and clamp. It keeps its value across bubbles and stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q  <= 8'd0;
         cb_q <= 8'd0;
         cr_q <= 8'd0;
      end else if (advance && v2) begin
         y_q  <= scale(s_y,  18'sd0);
         cb_q <= scale(s_cb, 18'sd128);
         cr_q <= scale(s_cr, 18'sd128);
      end
   end

   // Position of the presented pixel within its block. It steps on each output transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (v3 && bus.out_ready) begin
         cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end
   end
endmodule
